imem_fetch: RTL and testbench
=============================

IMEM_FETCH -- requirements
Module: imem_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning byte address of the first fetch after reset.
REQ-002 SHALL have parameter MEM_WORDS, default 1024, meaning the instruction memory depth in 32-bit words.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, meaning reset, asynchronous and active-low.
REQ-005 SHALL have port imem_addr, output, 32, meaning word index into instruction memory: {2'b00, fetch_pc[31:2]}.
REQ-006 SHALL have port imem_data, input, 32, meaning the instruction word returned combinationally for imem_addr.
REQ-007 SHALL have port redirect_valid, input, 1, meaning a branch or jump target is presented this cycle.
REQ-008 SHALL have port redirect_pc, input, 32, meaning the target byte address, qualified by redirect_valid.
REQ-009 SHALL have port out_valid, output, 1, meaning out_instr, out_pc and out_pc4 hold a fetched instruction.
REQ-010 SHALL have port out_ready, input, 1, meaning the decode stage accepts the output this cycle.
REQ-011 SHALL have ports out_instr, out_pc and out_pc4, each output, 32, meaning instruction word, its byte address, and that address + 4.
REQ-012 SHALL have port fault, output, 1, meaning a sticky misaligned or out-of-range fetch error.
REQ-013 SHALL have port instr_count, output, 32, meaning the number of accepted transfers, wrapping modulo 2^32.

Function
REQ-014 SHALL implement the FSM states START, RUN and FAULT; START moves to RUN unconditionally after one clock.
REQ-015 SHALL define load as (state == RUN) && (!out_valid || out_ready) && !redirect_valid && (fetch_pc[31:2] < MEM_WORDS).
REQ-016 SHALL, on load: out_instr <= imem_data, out_pc <= fetch_pc, out_pc4 <= fetch_pc + 4, out_valid <= 1 and fetch_pc <= fetch_pc + 4, giving one-cycle fetch latency.
REQ-017 SHALL hold out_valid, out_instr, out_pc and out_pc4 stable while out_valid=1 and out_ready=0.
REQ-018 SHALL, when out_valid && out_ready && !load, clear out_valid.
REQ-019 SHALL give redirect_valid priority over load in RUN: out_valid <= 0 and fetch_pc <= redirect_pc, so the first target instruction appears after a one-cycle bubble.
REQ-020 SHALL count a transfer that coincides with a redirect in instr_count; the flushed output is not replayed.
REQ-021 SHALL, when redirect_pc[1:0] != 0 in RUN, enter FAULT, set fault=1 and leave fetch_pc unchanged.
REQ-022 SHALL, in RUN with fetch_pc[31:2] >= MEM_WORDS and no redirect, enter FAULT with fault=1; the PC never wraps to 0.
REQ-023 SHALL, in FAULT, still allow an already-valid output to drain through the handshake, then hold out_valid=0, ignore redirects and stay there until reset.
REQ-024 SHALL increment instr_count on every cycle with out_valid && out_ready.

Reset
REQ-025 SHALL, while reset_n=0: state=START, fetch_pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, out_pc4=0, fault=0, instr_count=0.
REQ-026 SHALL abandon any in-flight output when reset is asserted mid-operation, with no partial transfer.

Structure
REQ-027 SHALL place the FSM state encoding (START, RUN, FAULT) and the default RESET_PC constant in the shared CPU package.
REQ-028 SHALL be a single module with no sub-modules; the instruction memory is instantiated outside it.

Verification
REQ-029 SHALL cover reset release with out_ready=1 and memory words 0..3 = 0x11,0x22,0x33,0x44 -> out_valid high from the 2nd edge; out_pc 0,4,8,12 on consecutive cycles; instr_count=4 after four accepts.
REQ-030 SHALL cover out_ready=0 for 5 cycles while out_pc=4 -> out_instr=0x22 stable, imem_addr=2 held, instr_count unchanged.
REQ-031 SHALL cover redirect_pc=0x40 together with out_valid=1 and out_ready=1 at out_pc=8 -> instr_count+1; out_valid=0 for one cycle; next out_pc=0x40 and out_pc4=0x44.
REQ-032 SHALL cover redirect_pc=0x42 -> fault=1 the next cycle, out_valid=0 after any held output is accepted, and the block stays in FAULT until reset_n pulses low.
REQ-033 SHALL cover MEM_WORDS=4 with sequential fetch -> out_pc 0,4,8,12, then fault=1 and no fetch at address 16.
REQ-034 SHALL cover reset_n asserted asynchronously mid-cycle while out_valid=1 -> all outputs at their reset values immediately, before the next clock edge.

Source files
------------

// File: rtl/imem_fetch_pkg.sv
// Shared CPU definitions for the instruction fetch stage: FSM encoding and
// the default boot address.
package imem_fetch_pkg;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/imem_fetch.sv
// Instruction fetch stage: reads a combinational instruction memory and
// presents one instruction per cycle to decode over a valid/ready output.
module imem_fetch
    import imem_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic         clk,
    input  logic         reset_n,
    output logic [31:0]  imem_addr,
    input  logic [31:0]  imem_data,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_instr,
    output logic [31:0]  out_pc,
    output logic [31:0]  out_pc4,
    output logic         fault,
    output logic [31:0]  instr_count,
    output fetch_state_e state_dbg
);

    localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

    // Handshake: a transfer happens on a rising edge where out_valid and
    // out_ready are both high; while out_valid=1 and out_ready=0 the payload
    // (out_instr, out_pc, out_pc4) is held unchanged.

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         out_valid_q, out_valid_d;
    logic [31:0]  out_instr_q, out_instr_d;
    logic [31:0]  out_pc_q, out_pc_d;
    logic [31:0]  out_pc4_q, out_pc4_d;
    logic         fault_q, fault_d;
    logic [31:0]  count_q, count_d;

    logic xfer;
    logic in_range;
    logic load;

    assign imem_addr = {2'b00, fetch_pc_q[31:2]};
    assign xfer      = out_valid_q && out_ready;
    assign in_range  = {2'b00, fetch_pc_q[31:2]} < MEM_WORDS_W;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        out_pc4_d   = out_pc4_q;
        fault_d     = fault_q;
        count_d     = count_q;
        load        = 1'b0;

        // An accepted output empties the slot unless a load refills it below.
        if (xfer) begin
            count_d     = count_q + 32'd1;
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_START: state_d = ST_RUN;
            ST_RUN: begin
                if (redirect_valid) begin
                    if (redirect_pc[1:0] != 2'b00) begin
                        // Bad target: keep the PC, let any held output drain.
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                    end else begin
                        out_valid_d = 1'b0;
                        fetch_pc_d  = redirect_pc;
                    end
                end else if (!in_range) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                end else if (!out_valid_q || out_ready) begin
                    load = 1'b1;
                end
            end
            ST_FAULT: ;
            default: state_d = ST_FAULT;
        endcase

        if (load) begin
            out_instr_d = imem_data;
            out_pc_d    = fetch_pc_q;
            out_pc4_d   = fetch_pc_q + 32'd4;
            out_valid_d = 1'b1;
            fetch_pc_d  = fetch_pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_START;
            fetch_pc_q  <= RESET_PC;
            out_valid_q <= 1'b0;
            out_instr_q <= 32'd0;
            out_pc_q    <= 32'd0;
            out_pc4_q   <= 32'd0;
            fault_q     <= 1'b0;
            count_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            out_pc4_q   <= out_pc4_d;
            fault_q     <= fault_d;
            count_q     <= count_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_instr   = out_instr_q;
    assign out_pc      = out_pc_q;
    assign out_pc4     = out_pc4_q;
    assign fault       = fault_q;
    assign instr_count = count_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_imem_fetch.sv
// Bench for imem_fetch: directed scenarios plus a randomized run checked
// against a PC-stream model of the fetch stage.
module tb_imem_fetch;
    import imem_fetch_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [31:0]  imem_addr, imem_data;
    logic         redirect_valid = 1'b0;
    logic [31:0]  redirect_pc = 32'd0;
    logic         out_valid, out_ready = 1'b1;
    logic [31:0]  out_instr, out_pc, out_pc4, instr_count;
    logic         fault;
    fetch_state_e state_dbg;

    // Small-memory instance for the end-of-memory scenario.
    logic         r4_n = 1'b0;
    logic [31:0]  addr4, data4, instr4, pc4o, pc4p4, cnt4;
    logic         rv4 = 1'b0;
    logic [31:0]  rpc4 = 32'd0;
    logic         ov4, ready4 = 1'b1, fault4;
    fetch_state_e st4;

    logic [31:0] mem [0:1023];
    logic [31:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign imem_data = (imem_addr < 32'd1024) ? mem[imem_addr[9:0]] : 32'hDEAD_BEEF;
    assign data4     = (addr4 < 32'd4) ? mem[addr4[9:0]] : 32'hBAD0_0000;

    imem_fetch dut (
        .clk(clk), .reset_n(reset_n), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_pc4(out_pc4), .fault(fault),
        .instr_count(instr_count), .state_dbg(state_dbg)
    );

    imem_fetch #(.MEM_WORDS(4)) dut4 (
        .clk(clk), .reset_n(r4_n), .imem_addr(addr4), .imem_data(data4),
        .redirect_valid(rv4), .redirect_pc(rpc4),
        .out_valid(ov4), .out_ready(ready4), .out_instr(instr4),
        .out_pc(pc4o), .out_pc4(pc4p4), .fault(fault4),
        .instr_count(cnt4), .state_dbg(st4)
    );

    task automatic do_reset();
        reset_n = 1'b0;
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_pc !== 32'd0 || out_instr !== 32'd0 || out_pc4 !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b pc=%h instr=%h pc4=%h, expected all zero",
                     out_valid, out_pc, out_instr, out_pc4);
        end
        checks++;
        if (fault !== 1'b0 || instr_count !== 32'd0 || imem_addr !== 32'd0 || state_dbg !== ST_START) begin
            errors++;
            $display("FAIL reset_state: got fault=%b cnt=%0d addr=%h st=%0d, expected 0/0/0/START",
                     fault, instr_count, imem_addr, state_dbg);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] e_instr;
        do_reset();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL seq_first_edge: got out_valid=%b expected 0", out_valid);
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            e_instr = 32'(32'h11 * (i + 1));
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * i) || out_pc4 !== 32'(4 * i + 4) || out_instr !== e_instr) begin
                errors++;
                $display("FAIL seq_word%0d: got v=%b pc=%h pc4=%h instr=%h expected 1/%h/%h/%h",
                         i, out_valid, out_pc, out_pc4, out_instr, 32'(4 * i), 32'(4 * i + 4), e_instr);
            end
            @(negedge clk);
        end
        checks++;
        if (instr_count !== 32'd4) begin
            errors++;
            $display("FAIL seq_count: got %0d expected 4", instr_count);
        end
    endtask

    task automatic test_stall();
        do_reset();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'd4 || out_instr !== 32'h22 ||
                imem_addr !== 32'd2 || instr_count !== 32'd1) begin
                errors++;
                $display("FAIL stall_hold%0d: got v=%b pc=%h instr=%h addr=%h cnt=%0d expected 1/4/22/2/1",
                         i, out_valid, out_pc, out_instr, imem_addr, instr_count);
            end
        end
        out_ready = 1'b1;
    endtask

    task automatic test_redirect();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'd8) begin
            errors++;
            $display("FAIL redir_pre: got v=%b pc=%h expected 1/8", out_valid, out_pc);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || instr_count !== 32'd3) begin
            errors++;
            $display("FAIL redir_bubble: got v=%b cnt=%0d expected 0/3", out_valid, instr_count);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_pc4 !== 32'h44 || out_instr !== mem[16]) begin
            errors++;
            $display("FAIL redir_target: got v=%b pc=%h pc4=%h instr=%h expected 1/40/44/%h",
                     out_valid, out_pc, out_pc4, out_instr, mem[16]);
        end
    endtask

    task automatic test_misaligned();
        out_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h42;
        @(negedge clk);
        checks++;
        if (fault !== 1'b1 || state_dbg !== ST_FAULT || out_valid !== 1'b1 || out_pc !== 32'h40) begin
            errors++;
            $display("FAIL misal_enter: got fault=%b st=%0d v=%b pc=%h expected 1/FAULT/1/40",
                     fault, state_dbg, out_valid, out_pc);
        end
        redirect_pc = 32'h80;
        out_ready = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || instr_count !== 32'd4) begin
            errors++;
            $display("FAIL misal_drain: got v=%b cnt=%0d expected 0/4", out_valid, instr_count);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || fault !== 1'b1 || state_dbg !== ST_FAULT || imem_addr !== 32'd17) begin
                errors++;
                $display("FAIL misal_stay%0d: got v=%b fault=%b st=%0d addr=%h expected 0/1/FAULT/11",
                         i, out_valid, fault, state_dbg, imem_addr);
            end
        end
        do_reset();
        checks++;
        if (fault !== 1'b0 || state_dbg !== ST_START) begin
            errors++;
            $display("FAIL misal_reset: got fault=%b st=%0d expected 0/START", fault, state_dbg);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (4) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL async_pre: got out_valid=%b expected 1", out_valid);
        end
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_pc !== 32'd0 || out_pc4 !== 32'd0 || out_instr !== 32'd0 ||
            instr_count !== 32'd0 || fault !== 1'b0 || imem_addr !== 32'd0 || state_dbg !== ST_START) begin
            errors++;
            $display("FAIL async_reset: got v=%b pc=%h pc4=%h instr=%h cnt=%0d fault=%b addr=%h st=%0d expected reset values",
                     out_valid, out_pc, out_pc4, out_instr, instr_count, fault, imem_addr, state_dbg);
        end
        @(negedge clk);
    endtask

    task automatic test_mem_limit();
        logic [31:0] e;
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(4 * i));
        @(negedge clk);
        r4_n = 1'b1;
        ready4 = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (ov4 && ready4) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL limit_extra: got transfer pc=%h expected none", pc4o);
                end else begin
                    e = exp_q.pop_front();
                    if (pc4o !== e || instr4 !== mem[e[11:2]]) begin
                        errors++;
                        $display("FAIL limit_pc: got pc=%h instr=%h expected %h/%h", pc4o, instr4, e, mem[e[11:2]]);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL limit_missing: got %0d outstanding expected 0", exp_q.size());
        end
        checks++;
        if (fault4 !== 1'b1 || ov4 !== 1'b0 || cnt4 !== 32'd4 || addr4 !== 32'd4 || st4 !== ST_FAULT) begin
            errors++;
            $display("FAIL limit_fault: got fault=%b v=%b cnt=%0d addr=%h st=%0d expected 1/0/4/4/FAULT",
                     fault4, ov4, cnt4, addr4, st4);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, held_pc, tgt;
        logic        rdy, redir, prev_hold;
        int          mcount;
        do_reset();
        exp_pc = DEFAULT_RESET_PC;
        mcount = 0;
        prev_hold = 1'b0;
        held_pc = 32'd0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            rdy   = ($urandom_range(0, 9) < 7);
            redir = ($urandom_range(0, 15) == 0);
            tgt   = 32'($urandom_range(0, 127)) * 32'd4;
            if (prev_hold) begin
                checks++;
                if (out_valid !== 1'b1 || out_pc !== held_pc) begin
                    errors++;
                    $display("FAIL rand_hold: got v=%b pc=%h expected 1/%h", out_valid, out_pc, held_pc);
                end
            end
            out_ready = rdy;
            redirect_valid = redir;
            redirect_pc = tgt;
            if (out_valid && rdy) begin
                checks++;
                if (out_pc !== exp_pc || out_pc4 !== exp_pc + 32'd4 || out_instr !== mem[exp_pc[11:2]]) begin
                    errors++;
                    $display("FAIL rand_xfer: got pc=%h pc4=%h instr=%h expected %h/%h/%h",
                             out_pc, out_pc4, out_instr, exp_pc, exp_pc + 32'd4, mem[exp_pc[11:2]]);
                end
                exp_pc = exp_pc + 32'd4;
                mcount++;
            end
            if (redir) exp_pc = tgt;
            prev_hold = out_valid && !rdy && !redir;
            held_pc = out_pc;
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++;
        if (instr_count !== 32'(mcount) || fault !== 1'b0) begin
            errors++;
            $display("FAIL rand_count: got cnt=%0d fault=%b expected %0d/0", instr_count, fault, mcount);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[0] = 32'h11;
        mem[1] = 32'h22;
        mem[2] = 32'h33;
        mem[3] = 32'h44;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_misaligned();
        test_async_reset();
        test_mem_limit();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
